// File: rtl/ser_to_par_rcv.sv
// Serial-in / parallel-out receiver: collects W bits (MSB first) after a start strobe and
// presents them on PO with a valid/ack handshake. Optional macro: PARITY_CHK_EN (even parity bit).
module ser_to_par_rcv #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         SI,
  input  logic         ack,
  output logic [W-1:0] PO,
  output logic         valid,
  output logic         busy,
  output logic         ovf,
  output logic         perr
);

  localparam int unsigned LAST = W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  // Only W-1 history bits are needed; the W-th bit comes straight from SI.
  logic [W-2:0]   sreg, sreg_n;
  logic [W-1:0]   po_n;
  logic [W-1:0]   shifted;
  logic           valid_n, ovf_n, busy_n;
`ifdef PARITY_CHK_EN
  logic           perr_n;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      PO    <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sreg  <= sreg_n;
      PO    <= po_n;
      valid <= valid_n;
      ovf   <= ovf_n;
      busy  <= busy_n;
    end
  end

`ifdef PARITY_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perr <= 1'b0;
    else      perr <= perr_n;
  end
`else
  assign perr = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    po_n    = PO;
    valid_n = valid;
    ovf_n   = ovf;
`ifdef PARITY_CHK_EN
    perr_n  = perr;
`endif
    shifted = {sreg, SI};

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        sreg_n = shifted[W-2:0];
        if (cnt == CW'(LAST)) begin
          cnt_n = '0;
          po_n  = shifted;
`ifdef PARITY_CHK_EN
          state_n = PAR;
`else
          valid_n = 1'b1;
          state_n = HOLD;
`endif
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef PARITY_CHK_EN
      PAR: begin
        valid_n = 1'b1;
        perr_n  = ^{PO, SI};
        state_n = HOLD;
      end
`endif
      HOLD: begin
        if (ack) begin
          valid_n = 1'b0;
          if (start) begin
            state_n = SHIFT;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else if (start) begin
          // Frame lost: consumer still owns PO, so keep it and flag overrun.
          ovf_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_ser_to_par_rcv.sv
// Self-checking bench for ser_to_par_rcv (W=8): table-driven vectors plus hand-written
// reset sequences. Honors PARITY_CHK_EN when defined.
module tb_ser_to_par_rcv;

  logic       clk = 1'b0;
  logic       rst, start, si, ack;
  logic [7:0] po;
  logic       valid, busy, ovf, perr;

  int errs   = 0;
  int checks = 0;

  ser_to_par_rcv #(.W(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .SI(si), .ack(ack),
    .PO(po), .valid(valid), .busy(busy), .ovf(ovf), .perr(perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, d, a;
    logic       ev, eb, eo, ep;
    logic [7:0] epo;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] m_po;
  logic       m_ovf, m_perr;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic s, d, a, ev, eb);
    tbl.push_back('{s, d, a, ev, eb, m_ovf, m_perr, m_po});
  endtask

  // Data bits of one frame (start already issued); noise puts start/ack strobes mid-frame.
  task automatic add_frame(input logic [7:0] w, input logic par, input logic noise);
    for (int i = 0; i < 8; i++) begin
      logic last;
      last = (i == 7);
      if (last) m_po = w;
`ifdef PARITY_CHK_EN
      push(noise && i == 3, w[7-i], noise && i == 5, 1'b0, 1'b1);
`else
      push(noise && i == 3, w[7-i], noise && i == 5, last, 1'b1);
`endif
    end
`ifdef PARITY_CHK_EN
    m_perr = ^{w, par};
    push(noise, par, 1'b0, 1'b1, 1'b1);
`else
    if (par) m_perr = 1'b0;
`endif
  endtask

  task automatic step(input logic s, d, a);
    start = s; si = d; ack = a;
    @(posedge clk); #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, eb, eo, ep, input logic [7:0] epo);
    chk({tag, ".valid"}, 8'(valid), 8'(ev));
    chk({tag, ".busy"},  8'(busy),  8'(eb));
    chk({tag, ".ovf"},   8'(ovf),   8'(eo));
    chk({tag, ".perr"},  8'(perr),  8'(ep));
    chk({tag, ".PO"},    po,        epo);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; si = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    m_po = 8'h00; m_ovf = 1'b0; m_perr = 1'b0;
    // Basic frame 0x0A
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_frame(8'h0A, 1'b0, 1'b0);
    // Hold without ack, then an overrun start
    for (int i = 0; i < 5; i++) push(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    m_ovf = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // ack while idle is ignored
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Frame 0x3C with stray start/ack strobes mid-frame
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_frame(8'h3C, 1'b0, 1'b1);
    // Back-to-back: ack and start together, then 0xA5
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    add_frame(8'hA5, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PARITY_CHK_EN
    // Bad parity on 0x0A
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_frame(8'h0A, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].s, tbl[i].d, tbl[i].a);
      chk_all(tag, tbl[i].ev, tbl[i].eb, tbl[i].eo, tbl[i].ep, tbl[i].epo);
    end

    // Reset in the middle of a frame
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    chk("mid.busy", 8'(busy), 8'h01);
    rst = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Fresh frame 0xFF after reset
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
    chk_all("ff.b7", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0);
`ifdef PARITY_CHK_EN
    chk_all("ff.b8", 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 1'b0);
`endif
    chk_all("ff.done", 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 1'b1);
    chk_all("ff.ack", 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
